// File: rtl/minifloat_pkg.sv
// Shared types for consumers of the int2float minifloat stream.
// Codes are {E[2:0], M[3:0]}; decoded magnitude is M << E (0..1920).
package minifloat_pkg;

  localparam int unsigned MF_E_W   = 3;
  localparam int unsigned MF_M_W   = 4;
  localparam int unsigned MF_VAL_W = 11;

  typedef struct packed {
    logic [MF_E_W-1:0] e;
    logic [MF_M_W-1:0] m;
  } mf_code_t;

  typedef logic [MF_VAL_W-1:0] mf_val_t;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } accum_state_t;

endpackage

// File: rtl/minifloat_decode.sv
// Combinational minifloat decoder: value = zero-extend(M) << E.
// Ports:
//   code  in   mf_code_t  minifloat code {e, m}
//   val   out  mf_val_t   unsigned integer magnitude
module minifloat_decode
  import minifloat_pkg::*;
(
  input  mf_code_t code,
  output mf_val_t  val
);

  assign val = MF_VAL_W'(code.m) << code.e;

endmodule

// File: rtl/minifloat_window_accum.sv
// Windowed accumulator of decoded minifloat samples.
// Sums WINDOW decoded codes (or fewer on flush) and presents the sum and
// sample count on a valid/ready output held until accepted.
// Optional macro MINIFLOAT_ACCUM_MAX_EN adds out_max, the largest decoded
// sample of the emitted window.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input code handshake; in_e/in_m code fields
//   flush               close a partial window
//   out_valid/out_ready result handshake
//   out_sum, out_cnt    window sum and number of samples (1..WINDOW)
//   out_max             (macro only) largest decoded sample in the window
module minifloat_window_accum
  import minifloat_pkg::*;
#(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned SUM_W  = 11 + $clog2(WINDOW)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MF_E_W-1:0]        in_e,
  input  logic [MF_M_W-1:0]        in_m,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_sum,
  output logic [$clog2(WINDOW):0]  out_cnt
`ifdef MINIFLOAT_ACCUM_MAX_EN
  ,
  output logic [MF_VAL_W-1:0]      out_max
`endif
);

  localparam int unsigned CNT_W = $clog2(WINDOW) + 1;

  accum_state_t     state;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;

  mf_code_t         code;
  mf_val_t          val;
  logic             accept;
  logic [SUM_W-1:0] sum_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             window_full;

  assign code = '{e: in_e, m: in_m};

  minifloat_decode u_decode (
    .code (code),
    .val  (val)
  );

  // Candidate running totals if the current beat is taken.
  always_comb begin
    accept      = in_valid & in_ready;
    sum_nxt     = sum_q + SUM_W'(val);
    cnt_nxt     = cnt_q + CNT_W'(1);
    window_full = (cnt_nxt == CNT_W'(WINDOW));
  end

`ifdef MINIFLOAT_ACCUM_MAX_EN
  mf_val_t max_q;
  mf_val_t max_nxt;

  always_comb begin
    max_nxt = (val > max_q) ? val : max_q;
  end
`endif

  // Accumulate in ACC, present and hold the result in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      sum_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
`ifdef MINIFLOAT_ACCUM_MAX_EN
      max_q     <= '0;
      out_max   <= '0;
`endif
    end else begin
      unique case (state)
        ACC: begin
          if (accept) begin
            sum_q <= sum_nxt;
            cnt_q <= cnt_nxt;
`ifdef MINIFLOAT_ACCUM_MAX_EN
            max_q <= max_nxt;
`endif
            if (window_full || flush) begin
              out_sum   <= sum_nxt;
              out_cnt   <= cnt_nxt;
`ifdef MINIFLOAT_ACCUM_MAX_EN
              out_max   <= max_nxt;
`endif
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= HOLD;
            end
          end else if (flush && (cnt_q != '0)) begin
            out_sum   <= sum_q;
            out_cnt   <= cnt_q;
`ifdef MINIFLOAT_ACCUM_MAX_EN
            out_max   <= max_q;
`endif
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Input reopens only after the handshake edge: no bypass.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            sum_q     <= '0;
            cnt_q     <= '0;
`ifdef MINIFLOAT_ACCUM_MAX_EN
            max_q     <= '0;
`endif
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_minifloat_window_accum.sv
// Scoreboard bench for minifloat_window_accum (WINDOW=8).
// Expected results are pushed when a window is closed; a monitor pops and
// compares on every output handshake and checks hold stability.
module tb_minifloat_window_accum;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned SUM_W  = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_e;
  logic [3:0]        in_m;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [3:0]        out_cnt;
`ifdef MINIFLOAT_ACCUM_MAX_EN
  logic [10:0]       out_max;
`else
  logic [10:0]       out_max;
  assign out_max = '0;
`endif

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [3:0]       cnt;
    logic [10:0]      mx;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  minifloat_window_accum #(.WINDOW(WINDOW), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_e      (in_e),
    .in_m      (in_m),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt)
`ifdef MINIFLOAT_ACCUM_MAX_EN
    ,
    .out_max   (out_max)
`endif
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int s, input int c, input int mx);
    exp_t e;
    e.sum = SUM_W'(s);
    e.cnt = 4'(c);
    e.mx  = 11'(mx);
    exp_q.push_back(e);
  endtask

  // Drive one beat (optionally with flush) and wait until it is accepted.
  task automatic beat(input logic [2:0] e, input logic [3:0] m, input logic fl);
    int guard = 0;
    in_valid = 1'b1;
    in_e     = e;
    in_m     = m;
    flush    = fl;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic flush_only();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while ((out_valid || exp_q.size() != 0) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(name, guard < 100 ? 1 : 0, 1);
  endtask

  // Monitor: compare on handshake, check stability while stalled.
  logic             stalled = 1'b0;
  logic [SUM_W-1:0] held_sum;
  logic [3:0]       held_cnt;
  logic [10:0]      held_max;

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else if (out_valid) begin
      if (stalled) begin
        chk("hold_sum", int'(out_sum), int'(held_sum));
        chk("hold_cnt", int'(out_cnt), int'(held_cnt));
        chk("hold_max", int'(out_max), int'(held_max));
      end
      if (out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_sum", int'(out_sum), int'(e.sum));
          chk("out_cnt", int'(out_cnt), int'(e.cnt));
`ifdef MINIFLOAT_ACCUM_MAX_EN
          chk("out_max", int'(out_max), int'(e.mx));
`endif
        end
      end else begin
        stalled  = 1'b1;
        held_sum = out_sum;
        held_cnt = out_cnt;
        held_max = out_max;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_e = '0; in_m = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum",   int'(out_sum), 0);
    chk("rst_out_cnt",   int'(out_cnt), 0);

    // Full window of max codes, with latency check
    push_exp(15360, 8, 1920);
    for (int i = 0; i < 8; i++) begin
      beat(3'd7, 4'd15, 1'b0);
      if (i == 6) chk("no_early_valid", int'(out_valid), 0);
    end
    chk("latency_valid", int'(out_valid), 1);
    wait_idle("full_window_drain");

    // Mixed decode
    push_exp(1374, 8, 1024);
    beat(3'd0, 4'd5, 1'b0);  beat(3'd3, 4'd9, 1'b0);
    beat(3'd1, 4'd8, 1'b0);  beat(3'd2, 4'd4, 1'b0);
    beat(3'd0, 4'd0, 1'b0);  beat(3'd7, 4'd8, 1'b0);
    beat(3'd4, 4'd15, 1'b0); beat(3'd0, 4'd1, 1'b0);
    wait_idle("mixed_drain");

    // Backpressure: stall with input pending, nothing consumed
    out_ready = 1'b0;
    push_exp(120, 8, 15);
    for (int i = 0; i < 8; i++) beat(3'd0, 4'd15, 1'b0);
    in_valid = 1'b1; in_e = 3'd5; in_m = 4'd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("bp_drain");
    push_exp(16, 8, 2);
    for (int i = 0; i < 8; i++) beat(3'd0, 4'd2, 1'b0);
    wait_idle("after_bp_drain");

    // Flush after three beats
    push_exp(36, 3, 12);
    for (int i = 0; i < 3; i++) beat(3'd2, 4'd3, 1'b0);
    flush_only();
    wait_idle("flush_drain");

    // Flush coincident with fourth beat
    push_exp(40, 4, 12);
    for (int i = 0; i < 3; i++) beat(3'd2, 4'd3, 1'b0);
    beat(3'd1, 4'd2, 1'b1);
    wait_idle("flush_coinc_drain");

    // Flush with empty window: no output
    flush_only();
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_no_valid", int'(out_valid), 0);
      @(posedge clk); #1;
    end

    // Reset mid-window discards partial state
    for (int i = 0; i < 5; i++) beat(3'd6, 4'd3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    push_exp(8, 8, 1);
    for (int i = 0; i < 8; i++) beat(3'd0, 4'd1, 1'b0);
    wait_idle("midrst_drain");

    chk("scoreboard_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/minifloat_window_accum.md
Name: minifloat_window_accum

Overview:
- Downstream consumer of the int2float converter stage: takes the 7-bit minifloat codes {E[2:0], M[3:0]} one per beat over a valid/ready stream.
- Decodes each code back to an integer magnitude and accumulates WINDOW samples.
- Emits the window sum and sample count over an output valid/ready handshake.
- Used for block-average and energy measurement on compressed samples.

Parameters:
- WINDOW, 8, samples per window; power of two, 2..64.
- SUM_W, 11+$clog2(WINDOW), accumulator/output width; sized so the sum cannot overflow.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input code valid.
- in_ready  output  1  block can accept a code this cycle.
- in_e  input  3  exponent E.
- in_m  input  4  mantissa M.
- flush  input  1  single-cycle pulse; close a partial window.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  SUM_W  sum of decoded samples in the window.
- out_cnt  output  $clog2(WINDOW)+1  number of samples in out_sum (1..WINDOW).

Behaviour:
- Decode rule: value = zero-extend(M) << E, 11 bits unsigned, range 0..1920.
  - Examples: E=0,M=5 -> 5; E=3,M=9 -> 72; E=7,M=15 -> 1920.
- The state machine has two states, ACC and HOLD.
- Reset: state=ACC, sum=0, cnt=0, out_valid=0, out_sum=0, out_cnt=0, in_ready=1 (in_ready is valid in the first cycle after rst deasserts).
- ACC:
  - in_ready=1 and out_valid=0.
  - An accepted beat (in_valid&in_ready) adds the decoded value to sum and increments cnt.
  - If the accepted beat makes cnt reach WINDOW, or flush=1 in the same cycle, then in the next cycle: out_sum=sum+value, out_cnt=cnt+1, out_valid=1, state=HOLD.
  - flush with no accepted beat:
    - cnt>0: emit sum/cnt, go to HOLD.
    - cnt==0: ignored, no output.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_sum and out_cnt are held stable while out_valid=1 and out_ready=0.
  - flush is ignored.
  - When out_ready=1: out_valid drops next cycle, sum=0, cnt=0, state=ACC.
  - No input bypass: a new input is accepted no earlier than the cycle after the handshake.
- Latency: result visible 1 cycle after the last accepted beat. Throughput: WINDOW samples per WINDOW+1 cycles minimum.
- in_e/in_m are ignored when in_valid=0. in_valid held during HOLD is not consumed.
- rst asserted mid-window or in HOLD discards all partial state and any pending result; no output is produced.
- Arithmetic is unsigned throughout; no truncation is possible given SUM_W.

Optional Feature:
- Macro MINIFLOAT_ACCUM_MAX_EN.
- Defined:
  - Adds output port out_max [10:0], the largest decoded value in the emitted window.
  - out_max follows the same timing and hold rules as out_sum.
  - Reset value 0; cleared with sum.
- Not defined: port and tracking logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package minifloat_pkg holds:
  - constants MF_E_W=3, MF_M_W=4, MF_VAL_W=11.
  - typedef mf_code_t (packed struct {e, m}).
  - typedef mf_val_t (logic [MF_VAL_W-1:0]).
  - enum accum_state_t {ACC, HOLD}.
- One sub-module, minifloat_decode: purely combinational, mf_code_t -> mf_val_t. It is reusable by other consumers of the converter and testable in isolation.

Test Plan:
- Full window, WINDOW=8: eight beats E=7,M=15 back-to-back, out_ready=1 -> one result out_sum=15360, out_cnt=8, out_valid high exactly 1 cycle after 8th beat.
- Mixed decode: beats (0,5),(3,9),(1,8),(2,4),(0,0),(7,8),(4,15),(0,1) -> out_sum=5+72+16+16+0+1024+240+1=1374, out_cnt=8.
- Backpressure: after a full window, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_sum/out_cnt stable, no input consumed; out_ready=1 -> next window starts with sum=0.
- Flush:
  - 3 beats of (2,3)=12 then flush -> out_sum=36, out_cnt=3.
  - Flush coincident with 4th beat (1,2)=4 -> out_sum=40, out_cnt=4.
  - Flush with cnt=0 -> no out_valid.
- Reset mid-window: 5 beats, assert rst 1 cycle -> no output; next 8 beats of (0,1) -> out_sum=8, out_cnt=8.
- MINIFLOAT_ACCUM_MAX_EN: mixed-decode window above -> out_max=1024. Build without the macro: port absent, out_sum still 1374.
